// File: rtl/ann_pkg.sv
// ann_pkg: shared ANN layer sizes, coefficient region encodings and fetch state type
package ann_pkg;
  localparam logic [1:0] SEL_L0 = 2'b00;
  localparam logic [1:0] SEL_L1 = 2'b01;
  localparam logic [1:0] SEL_L2 = 2'b10;
  localparam logic [1:0] SEL_IMG = 2'b11;
  localparam int N_INPUT = 64;
  localparam int N_HIDDEN0 = 16;
  localparam int N_HIDDEN1 = 8;
  localparam int N_OUTPUT = 10;
  localparam int IMG_WORDS = N_INPUT;
  localparam int L0_WORDS = N_INPUT * N_HIDDEN0;
  localparam int L1_WORDS = N_HIDDEN0 * N_HIDDEN1;
  localparam int L2_WORDS = N_HIDDEN1 * N_OUTPUT;
  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT_DATA, ST_STORE, ST_DONE} fetch_state_t;
  function automatic logic [9:0] last_index(input logic [1:0] sel);
    return sel == SEL_IMG ? 10'(IMG_WORDS - 1) :
           sel == SEL_L0  ? 10'(L0_WORDS - 1)  :
           sel == SEL_L1  ? 10'(L1_WORDS - 1)  : 10'(L2_WORDS - 1);
  endfunction
endpackage

// File: rtl/fetch_word_counter.sv
// fetch_word_counter: 10-bit word up-counter; load latches the terminal index and restarts at 0
module fetch_word_counter (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       load,
  input  logic       clr,
  input  logic       en,
  input  logic [9:0] last_idx,
  output logic [9:0] count,
  output logic       tc
);
  logic [9:0] last_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count  <= '0;
      last_q <= '0;
    end else if (load) begin
      count  <= '0;
      last_q <= last_idx;
    end else if (clr) begin
      count  <= '0;
    end else if (en) begin
      count  <= count + 10'd1;
    end
  end
  assign tc = count == last_q;
endmodule

// File: rtl/coef_fetch_sequencer.sv
// coef_fetch_sequencer: streams one coefficient region from SRAM into the weight bank, one read at a time
module coef_fetch_sequencer
  import ann_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int IMG_BASE = 0,
  parameter int L0_BASE  = 64,
  parameter int L1_BASE  = 1088,
  parameter int L2_BASE  = 1216
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              request_coef,
  input  logic [1:0]        coef_select,
  input  logic              abort,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              wr_en,
  output logic [9:0]        wr_index,
  output logic [DATA_W-1:0] wr_data,
  output logic              image_weights_loaded,
  output logic              busy,
  output logic              req_overrun
);
  fetch_state_t      state;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] data_q;
  logic [9:0]        idx;
  logic              tc;
  logic              accept;
  logic [ADDR_W-1:0] sel_base;
  assign accept = state == ST_IDLE && request_coef;
  assign sel_base = coef_select == SEL_IMG ? ADDR_W'(IMG_BASE) :
                    coef_select == SEL_L0  ? ADDR_W'(L0_BASE)  :
                    coef_select == SEL_L1  ? ADDR_W'(L1_BASE)  : ADDR_W'(L2_BASE);
  fetch_word_counter u_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (accept),
    .clr      (busy && abort),
    .en       (state == ST_STORE && !tc),
    .last_idx (last_index(coef_select)),
    .count    (idx),
    .tc       (tc)
  );
  // abort outranks every transition, including a read returning in the same cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= ST_IDLE;
      base        <= '0;
      data_q      <= '0;
      req_overrun <= 1'b0;
    end else begin
      if (accept) begin
        base        <= sel_base;
        req_overrun <= 1'b0;
      end else if (busy && request_coef) begin
        req_overrun <= 1'b1;
      end
      if (busy && abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE:      if (request_coef) state <= ST_ISSUE;
          ST_ISSUE:     state <= ST_WAIT_DATA;
          ST_WAIT_DATA: if (mem_rvalid) begin
            data_q <= mem_rdata;
            state  <= ST_STORE;
          end
          ST_STORE:     state <= tc ? ST_DONE : ST_ISSUE;
          default:      state <= ST_IDLE;
        endcase
      end
    end
  end
  assign busy                 = state != ST_IDLE;
  assign mem_read             = state == ST_ISSUE;
  assign mem_addr             = mem_read ? base + ADDR_W'(idx) : '0;
  assign wr_en                = state == ST_STORE;
  assign wr_index             = wr_en ? idx : '0;
  assign wr_data              = wr_en ? data_q : '0;
  assign image_weights_loaded = state == ST_DONE;
endmodule

// File: tb/tb_coef_fetch_sequencer.sv
// tb_coef_fetch_sequencer: scoreboard bench; a latency-programmable SRAM model answers reads,
// expected reads/writes/completions are queued at request time and popped by a monitor
module tb_coef_fetch_sequencer;
  import ann_pkg::*;
  typedef struct {
    logic [31:0] v;
    int          cyc;
  } exp_t;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        request_coef = 1'b0;
  logic [1:0]  coef_select = 2'b00;
  logic        abort = 1'b0;
  logic        stray_rv = 1'b0;
  logic        model_rv = 1'b0;
  logic [15:0] model_data = '0;
  logic        mem_read;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        wr_en;
  logic [9:0]  wr_index;
  logic [15:0] wr_data;
  logic        image_weights_loaded;
  logic        busy;
  logic        req_overrun;
  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int lat = 1;
  int pend = 0;
  int last_t = 0;
  logic [15:0] paddr = '0;
  exp_t aq[$];
  exp_t wq[$];
  exp_t dq[$];
  assign mem_rvalid = model_rv | stray_rv;
  assign mem_rdata  = stray_rv ? 16'hDEAD : model_data;
  coef_fetch_sequencer dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .request_coef         (request_coef),
    .coef_select          (coef_select),
    .abort                (abort),
    .mem_read             (mem_read),
    .mem_addr             (mem_addr),
    .mem_rdata            (mem_rdata),
    .mem_rvalid           (mem_rvalid),
    .wr_en                (wr_en),
    .wr_index             (wr_index),
    .wr_data              (wr_data),
    .image_weights_loaded (image_weights_loaded),
    .busy                 (busy),
    .req_overrun          (req_overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [15:0] pat(input logic [15:0] a);
    return (a * 16'd7) ^ 16'h5A3C;
  endfunction
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction
  // SRAM model: read data returns exactly lat cycles after the read strobe
  always @(negedge clk) begin
    model_rv = 1'b0;
    if (!n_rst) pend = 0;
    else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          model_rv   = 1'b1;
          model_data = pat(paddr);
        end
      end
      if (mem_read) begin
        paddr = mem_addr;
        pend  = lat;
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (n_rst) begin
      if (mem_read) begin
        chk("rd_expected", 32'(aq.size() != 0), 32'd1);
        if (aq.size() != 0) begin
          e = aq.pop_front();
          chk("rd_addr", 32'(mem_addr), e.v);
          chk("rd_cycle", cyc, e.cyc);
        end
      end
      if (wr_en) begin
        chk("wr_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("wr_idx_data", {6'd0, wr_index, wr_data}, e.v);
          chk("wr_cycle", cyc, e.cyc);
        end
      end
      if (image_weights_loaded) begin
        chk("done_expected", 32'(dq.size() != 0), 32'd1);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end
  // cut > 0: only words 0..cut-1 are written, word cut is issued, then the fetch is aborted
  task automatic start_fetch(input logic [1:0] sel, input int l, input int cut);
    int base, n, t, n_iss, n_wr;
    exp_t e;
    base  = sel == SEL_IMG ? 0 : sel == SEL_L0 ? 64 : sel == SEL_L1 ? 1088 : 1216;
    n     = sel == SEL_IMG ? 64 : sel == SEL_L0 ? 1024 : sel == SEL_L1 ? 128 : 80;
    n_iss = cut > 0 ? cut + 1 : n;
    n_wr  = cut > 0 ? cut : n;
    @(negedge clk);
    t = cyc;
    lat = l;
    for (int k = 0; k < n_iss; k++) begin
      e.v = 32'(base + k);
      e.cyc = t + 1 + k * (l + 2);
      aq.push_back(e);
    end
    for (int k = 0; k < n_wr; k++) begin
      e.v = {6'd0, 10'(k), pat(16'(base + k))};
      e.cyc = t + 1 + k * (l + 2) + l + 1;
      wq.push_back(e);
    end
    if (cut == 0) begin
      e.v = 32'd1;
      e.cyc = t + 1 + n * (l + 2);
      dq.push_back(e);
    end
    request_coef = 1'b1;
    coef_select  = sel;
    last_t = t;
    @(negedge clk);
    request_coef = 1'b0;
  endtask
  task automatic wait_drain(input int budget);
    int b;
    b = budget;
    while ((aq.size() + wq.size() + dq.size()) != 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("drain_left", 32'(aq.size() + wq.size() + dq.size()), 32'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctl", {27'd0, mem_read, wr_en, image_weights_loaded, busy, req_overrun}, 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wr", {6'd0, wr_index, wr_data}, 32'd0);
    n_rst = 1'b1;
    @(negedge clk);
    start_fetch(SEL_L0, 1, 0);
    chk("l0_busy", 32'(busy), 32'd1);
    repeat (20) @(negedge clk);
    request_coef = 1'b1;
    coef_select  = SEL_IMG;
    @(negedge clk);
    request_coef = 1'b0;
    chk("overrun_set", 32'(req_overrun), 32'd1);
    wait_drain(1024 * 3 + 50);
    @(negedge clk);
    chk("overrun_sticky", 32'(req_overrun), 32'd1);
    chk("l0_idle", 32'(busy), 32'd0);
    start_fetch(SEL_IMG, 1, 0);
    chk("overrun_clr", 32'(req_overrun), 32'd0);
    wait_drain(64 * 3 + 50);
    start_fetch(SEL_L2, $urandom_range(1, 5), 0);
    chk("l2_issue", 32'(mem_read), 32'd1);
    stray_rv = 1'b1;
    @(negedge clk);
    stray_rv = 1'b0;
    wait_drain(80 * 7 + 50);
    @(negedge clk);
    stray_rv = 1'b1;
    @(negedge clk);
    stray_rv = 1'b0;
    chk("stray_idle_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("stray_idle_quiet", {30'd0, wr_en, busy}, 32'd0);
    start_fetch(SEL_L1, 4, 10);
    repeat (62) @(negedge clk);
    chk("abort_in_wait", {29'd0, mem_read, wr_en, busy}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_left", 32'(aq.size() + wq.size() + dq.size()), 32'd0);
    chk("abort_idle", {30'd0, wr_en, busy}, 32'd0);
    start_fetch(SEL_L1, 2, 0);
    request_coef = 1'b1;
    @(negedge clk);
    request_coef = 1'b0;
    repeat (22) @(negedge clk);
    chk("pre_rst_store", {30'd0, wr_en, req_overrun}, 32'd3);
    #1 n_rst = 1'b0;
    #1;
    chk("mid_rst_ctl", {27'd0, mem_read, wr_en, image_weights_loaded, busy, req_overrun}, 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_wr", {6'd0, wr_index, wr_data}, 32'd0);
    aq.delete();
    wq.delete();
    dq.delete();
    @(negedge clk);
    #1 n_rst = 1'b1;
    start_fetch(SEL_L1, 2, 0);
    wait_drain(128 * 4 + 50);
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, %0d of %0d checks failed so far", failed, tests);
    $fatal(1);
  end
endmodule
